// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants for the UART command decoder: the ASCII characters that make
// up the command set, the decoder state encoding, the time-field limits, and
// small arithmetic helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam logic [7:0] CHR_R     = 8'h52;
  localparam logic [7:0] CHR_C     = 8'h43;
  localparam logic [7:0] CHR_M     = 8'h4D;
  localparam logic [7:0] CHR_T     = 8'h54;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_SP    = 8'h20;
  localparam logic [7:0] CHR_0     = 8'h30;
  localparam logic [7:0] CHR_9     = 8'h39;
  // Clearing this bit folds an ASCII lowercase letter onto its uppercase form.
  localparam logic [7:0] CASE_MASK = 8'h20;

  localparam logic [6:0] HH_MAX = 7'd23;
  localparam logic [6:0] MS_MAX = 7'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIGITS  = 2'd1,
    WAIT_CR = 2'd2
  } state_t;

  // Two BCD-style digits to a binary value; 7 bits hold up to 99 with no truncation.
  function automatic logic [6:0] field_value(input logic [3:0] tens, input logic [3:0] ones);
    field_value = ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

  // Fold a letter to uppercase. Only meaningful for comparisons against letters.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    to_upper = b & ~CASE_MASK;
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// -----------------------------------------------------------------------------
// cmd_timeout_timer
// Counts idle cycles while a multi-byte command is in progress and flags expiry
// when TIMEOUT_CYCLES-1 idle cycles have already been counted and yet another
// idle cycle arrives. An accepted byte on the expiry cycle cancels the expiry.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   active  in   high while a command is partially received
//   clear   in   high when a byte is accepted this cycle (restarts the count)
//   expire  out  combinational expiry flag, registered by the decoder
// -----------------------------------------------------------------------------
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  output logic expire
);

  localparam logic [31:0] LAST_COUNT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count_r;

  // Idle-cycle counter: restarts on any accepted byte or when no command is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (!active || clear) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end

  // Expiry needs a further idle cycle once the limit is reached; a byte wins.
  always_comb begin
    expire = 1'b0;
    if (active && !clear && (count_r == LAST_COUNT)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Turns bytes popped from the UART RX FIFO into one-cycle control strobes
// (run/stop, clear, mode) and an atomic, range-checked set-time update from
// the command "Thhmmss<CR>". Letters are case-insensitive.
// Optional feature: define UART_CMD_TIMEOUT_EN to abandon a partial set-time
// command after TIMEOUT_CYCLES idle cycles (cmd_err is pulsed).
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   rx_data[7:0]   in   received byte
//   rx_valid       in   rx_data is consumed this cycle
//   run_stop_pulse out  run/stop toggle strobe
//   clear_pulse    out  clear strobe
//   mode_pulse     out  mode toggle strobe
//   set_valid      out  set_hh/mm/ss carry a new accepted time
//   set_hh[4:0]    out  hours
//   set_mm[5:0]    out  minutes
//   set_ss[5:0]    out  seconds
//   cmd_err        out  malformed, out-of-range or timed-out command strobe
//   busy           out  set-time command partially received
// -----------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       run_stop_pulse,
  output logic       clear_pulse,
  output logic       mode_pulse,
  output logic       set_valid,
  output logic [4:0] set_hh,
  output logic [5:0] set_mm,
  output logic [5:0] set_ss,
  output logic       cmd_err,
  output logic       busy
);

  state_t      state_r;
  logic [2:0]  idx_r;
  // Digits shift in from the right: [23:20] is the hours tens digit once six are in.
  logic [23:0] digits_r;

  logic [7:0]  upper_s;
  logic [7:0]  diff_s;
  logic        is_digit_s;
  logic        is_space_s;
  logic [6:0]  hh_s;
  logic [6:0]  mm_s;
  logic [6:0]  ss_s;
  logic        range_ok_s;
  logic        timeout_expire_s;

`ifdef UART_CMD_TIMEOUT_EN
  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .active (busy),
    .clear  (rx_valid),
    .expire (timeout_expire_s)
  );
`else
  assign timeout_expire_s = 1'b0;
`endif

  // Byte classification and range check of the buffered time fields.
  always_comb begin
    upper_s    = to_upper(rx_data);
    diff_s     = rx_data - CHR_0;
    // Bytes below '0' wrap to large values, so one unsigned compare covers both ends.
    is_digit_s = (diff_s <= (CHR_9 - CHR_0));
    is_space_s = (rx_data == CHR_CR) || (rx_data == CHR_LF) || (rx_data == CHR_SP);
    hh_s       = field_value(digits_r[23:20], digits_r[19:16]);
    mm_s       = field_value(digits_r[15:12], digits_r[11:8]);
    ss_s       = field_value(digits_r[7:4],   digits_r[3:0]);
    range_ok_s = (hh_s <= HH_MAX) && (mm_s <= MS_MAX) && (ss_s <= MS_MAX);
  end

  // Command FSM with registered strobes, busy flag and set-time outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      idx_r          <= 3'd0;
      digits_r       <= 24'd0;
      run_stop_pulse <= 1'b0;
      clear_pulse    <= 1'b0;
      mode_pulse     <= 1'b0;
      set_valid      <= 1'b0;
      set_hh         <= 5'd0;
      set_mm         <= 6'd0;
      set_ss         <= 6'd0;
      cmd_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      run_stop_pulse <= 1'b0;
      clear_pulse    <= 1'b0;
      mode_pulse     <= 1'b0;
      set_valid      <= 1'b0;
      cmd_err        <= 1'b0;
      if (rx_valid) begin
        case (state_r)
          IDLE: begin
            // Whitespace is tested on the raw byte: folding would alias '-' onto CR.
            if (is_space_s) begin
              state_r <= IDLE;
            end else begin
              case (upper_s)
                CHR_R: run_stop_pulse <= 1'b1;
                CHR_C: clear_pulse    <= 1'b1;
                CHR_M: mode_pulse     <= 1'b1;
                CHR_T: begin
                  state_r <= DIGITS;
                  idx_r   <= 3'd0;
                  busy    <= 1'b1;
                end
                default: cmd_err <= 1'b1;
              endcase
            end
          end
          DIGITS: begin
            if (is_digit_s) begin
              digits_r <= {digits_r[19:0], diff_s[3:0]};
              idx_r    <= idx_r + 3'd1;
              if (idx_r == 3'd5) begin
                state_r <= WAIT_CR;
              end else begin
                state_r <= DIGITS;
              end
            end else begin
              cmd_err <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end
          WAIT_CR: begin
            if ((rx_data == CHR_CR) && range_ok_s) begin
              set_hh    <= hh_s[4:0];
              set_mm    <= mm_s[5:0];
              set_ss    <= ss_s[5:0];
              set_valid <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
            busy    <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end else if (timeout_expire_s) begin
        cmd_err <= 1'b1;
        busy    <= 1'b0;
        state_r <= IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       run_stop_pulse, clear_pulse, mode_pulse, set_valid, cmd_err, busy;
  logic [4:0] set_hh;
  logic [5:0] set_mm, set_ss;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .run_stop_pulse (run_stop_pulse),
    .clear_pulse    (clear_pulse),
    .mode_pulse     (mode_pulse),
    .set_valid      (set_valid),
    .set_hh         (set_hh),
    .set_mm         (set_mm),
    .set_ss         (set_ss),
    .cmd_err        (cmd_err),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: the open set-time command is just the list of bytes received so far.
  byte unsigned pend[$];
  int           idle_cnt = 0;

  // Expected outputs after the next edge (n_*) and currently visible (e_*).
  logic       n_rs, n_cl, n_md, n_sv, n_err, n_busy;
  logic [4:0] n_hh;
  logic [5:0] n_mm, n_ss;
  logic       e_rs, e_cl, e_md, e_sv, e_err, e_busy;
  logic [4:0] e_hh;
  logic [5:0] e_mm, e_ss;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dval(input byte unsigned c);
    return int'(c) - 48;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    int hh, mm, ss;
    n_rs = 1'b0; n_cl = 1'b0; n_md = 1'b0; n_sv = 1'b0; n_err = 1'b0;
    if (r) begin
      pend.delete();
      idle_cnt = 0;
      n_hh = 5'd0; n_mm = 6'd0; n_ss = 6'd0;
    end else if (v) begin
      idle_cnt = 0;
      if (pend.size() == 0) begin
        case (d)
          8'h0D, 8'h0A, 8'h20: ;
          "R", "r": n_rs = 1'b1;
          "C", "c": n_cl = 1'b1;
          "M", "m": n_md = 1'b1;
          "T", "t": pend.push_back(d);
          default:  n_err = 1'b1;
        endcase
      end else if (pend.size() < 7) begin
        if (d >= "0" && d <= "9") pend.push_back(d);
        else begin
          n_err = 1'b1;
          pend.delete();
        end
      end else begin
        hh = dval(pend[1]) * 10 + dval(pend[2]);
        mm = dval(pend[3]) * 10 + dval(pend[4]);
        ss = dval(pend[5]) * 10 + dval(pend[6]);
        if (d == 8'h0D && hh <= 23 && mm <= 59 && ss <= 59) begin
          n_sv = 1'b1;
          n_hh = 5'(hh); n_mm = 6'(mm); n_ss = 6'(ss);
        end else begin
          n_err = 1'b1;
        end
        pend.delete();
      end
    end else if (pend.size() > 0) begin
`ifdef UART_CMD_TIMEOUT_EN
      idle_cnt++;
      if (idle_cnt == 16) begin
        n_err = 1'b1;
        pend.delete();
        idle_cnt = 0;
      end
`endif
    end
    n_busy = (pend.size() > 0);
  endtask

  // Expected values become visible at the same edge as the DUT's registers.
  always @(posedge clk) begin
    e_rs <= n_rs; e_cl <= n_cl; e_md <= n_md; e_sv <= n_sv; e_err <= n_err;
    e_busy <= n_busy; e_hh <= n_hh; e_mm <= n_mm; e_ss <= n_ss;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("run_stop_pulse", 32'(run_stop_pulse), 32'(e_rs));
      chk("clear_pulse",    32'(clear_pulse),    32'(e_cl));
      chk("mode_pulse",     32'(mode_pulse),     32'(e_md));
      chk("set_valid",      32'(set_valid),      32'(e_sv));
      chk("cmd_err",        32'(cmd_err),        32'(e_err));
      chk("busy",           32'(busy),           32'(e_busy));
      chk("set_hh",         32'(set_hh),         32'(e_hh));
      chk("set_mm",         32'(set_mm),         32'(e_mm));
      chk("set_ss",         32'(set_ss),         32'(e_ss));
    end
  end

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(posedge clk);
    #2;
    rst = r; rx_valid = v; rx_data = d;
    model_step(r, v, d);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    chk("lit_reset_busy", 32'(busy), 32'd0);
    chk("lit_reset_hh", 32'(set_hh), 32'd0);

    // Single-character commands back to back.
    step(1'b0, 1'b1, "R");
    step(1'b0, 1'b1, "c");
    chk("lit_run_stop", 32'(run_stop_pulse), 32'd1);
    step(1'b0, 1'b1, "M");
    chk("lit_clear", 32'(clear_pulse), 32'd1);
    chk("lit_run_stop_gone", 32'(run_stop_pulse), 32'd0);
    idle(1);
    chk("lit_mode", 32'(mode_pulse), 32'd1);
    idle(1);
    chk("lit_mode_gone", 32'(mode_pulse), 32'd0);

    // Valid set-time command.
    send_str("T1");
    chk("lit_busy_after_T", 32'(busy), 32'd1);
    send_str("23456");
    step(1'b0, 1'b1, 8'h0D);
    idle(1);
    chk("lit_set_valid", 32'(set_valid), 32'd1);
    chk("lit_hh_12", 32'(set_hh), 32'd12);
    chk("lit_mm_34", 32'(set_mm), 32'd34);
    chk("lit_ss_56", 32'(set_ss), 32'd56);
    chk("lit_busy_drop", 32'(busy), 32'd0);

    // Out-of-range hours, then a malformed digit sequence.
    send_str("T245959");
    step(1'b0, 1'b1, 8'h0D);
    idle(1);
    chk("lit_range_err", 32'(cmd_err), 32'd1);
    chk("lit_hh_kept", 32'(set_hh), 32'd12);
    send_str("T12a");
    idle(1);
    chk("lit_bad_digit_err", 32'(cmd_err), 32'd1);
    chk("lit_bad_digit_busy", 32'(busy), 32'd0);
    send_str("R");
    idle(1);
    chk("lit_idle_after_err", 32'(run_stop_pulse), 32'd1);

    // Unknown byte and ignored whitespace.
    send_str("X");
    step(1'b0, 1'b1, 8'h0A);
    send_str(" -");
    idle(2);

    // Boundary values, lowercase 't', and non-CR terminators.
    send_str("t235959");
    step(1'b0, 1'b1, 8'h0D);
    idle(1);
    chk("lit_hh_23", 32'(set_hh), 32'd23);
    send_str("T006000");
    step(1'b0, 1'b1, 8'h0D);
    send_str("T0000599");
    send_str("T000000");
    step(1'b0, 1'b1, 8'h0A);
    send_str("T0");
    idle(3);
    send_str("1234");
    idle(2);
    send_str("5");
    step(1'b0, 1'b1, 8'h0D);
    idle(2);

    // Partial command left idle.
    send_str("T12");
`ifdef UART_CMD_TIMEOUT_EN
    idle(16);
    step(1'b0, 1'b0, 8'h00);
    chk("lit_timeout_err", 32'(cmd_err), 32'd1);
    chk("lit_timeout_busy", 32'(busy), 32'd0);
    idle(3);
    send_str("R");
    idle(1);
    chk("lit_run_after_timeout", 32'(run_stop_pulse), 32'd1);
`else
    idle(20);
    chk("lit_still_busy", 32'(busy), 32'd1);
    send_str("x");
    idle(2);
`endif

    // Reset in the middle of a command discards it silently.
    send_str("T1234");
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_err", 32'(cmd_err), 32'd0);
    chk("lit_rst_hh", 32'(set_hh), 32'd0);
    send_str("T000000");
    step(1'b0, 1'b1, 8'h0D);
    idle(1);
    chk("lit_zero_set_valid", 32'(set_valid), 32'd1);
    chk("lit_zero_ss", 32'(set_ss), 32'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
